// File: rtl/sel_pipe_unit_if.sv
// Operand/result handshake bundle for sel_pipe_unit. The producer and consumer
// side uses master; the unit itself uses slave.
interface sel_pipe_unit_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   mode;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_eq;
  logic         out_err;
  logic [1:0]   occupancy;

  modport master (
    output in_valid, mode, A, B, out_ready,
    input  in_ready, out_valid, out_data, out_eq, out_err, occupancy
  );

  modport slave (
    input  in_valid, mode, A, B, out_ready,
    output in_ready, out_valid, out_data, out_eq, out_err, occupancy
  );
endinterface

// File: rtl/sel_pipe_unit.sv
// A/B/min/max select stage with a registered 2-entry skid buffer on the result
// path, so the ALU result mux can stall without dropping operand sets.
module sel_pipe_unit #(
  parameter int N     = 8,
  parameter int DEPTH = 2
) (
  input logic           clk,
  input logic           rst_n,
  sel_pipe_unit_if.slave bus
);

  generate
    if (DEPTH != 2 || N < 2) begin : g_bad_cfg
      $error("sel_pipe_unit: DEPTH must be 2 and N must be at least 2");
    end
  endgenerate

  typedef struct packed {
    logic [N-1:0] data;
    logic         eq;
    logic         err;
  } entry_t;

  // Equal operands fall through to A for every min/max mode.
  function automatic logic [N-1:0] select_result(
    input logic [2:0]   mode,
    input logic [N-1:0] a,
    input logic [N-1:0] b
  );
    logic signed [N-1:0] sa;
    logic signed [N-1:0] sb;
    logic [N-1:0]        r;
    sa = signed'(a);
    sb = signed'(b);
    case (mode)
      3'b000:  r = a;
      3'b001:  r = b;
      3'b010:  r = (b < a) ? b : a;
      3'b011:  r = (b > a) ? b : a;
      3'b100:  r = (sb < sa) ? b : a;
      3'b101:  r = (sb > sa) ? b : a;
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic is_reserved(input logic [2:0] mode);
    return mode[2] & mode[1];
  endfunction

  entry_t     res_p0;
  logic       vld_p0;
  logic       pop;
  entry_t     head_p1;
  entry_t     skid_p1;
  logic [1:0] occ_p1;

  // ---- stage 0: combinational select on the sampled operand set ----
  always_comb begin
    res_p0.data = select_result(bus.mode, bus.A, bus.B);
    res_p0.eq   = (bus.A == bus.B);
    res_p0.err  = is_reserved(bus.mode);
  end

  assign vld_p0 = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;

  // ---- stage 1: head register plus one skid slot ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_p1  <= 2'd0;
      head_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      case (occ_p1)
        2'd0: begin
          if (vld_p0) begin
            head_p1 <= res_p0;
            occ_p1  <= 2'd1;
          end
        end
        2'd1: begin
          if (vld_p0 && pop) begin
            head_p1 <= res_p0;
          end else if (vld_p0) begin
            skid_p1 <= res_p0;
            occ_p1  <= 2'd2;
          end else if (pop) begin
            occ_p1  <= 2'd0;
          end
        end
        default: begin
          // Full: in_ready is low, so only a pop can happen here.
          if (pop) begin
            head_p1 <= skid_p1;
            occ_p1  <= 2'd1;
          end
        end
      endcase
    end
  end

  // in_ready depends only on the registered count, never on out_ready.
  assign bus.in_ready  = ~occ_p1[1];
  assign bus.out_valid = (occ_p1 != 2'd0);
  assign bus.out_data  = head_p1.data;
  assign bus.out_eq    = head_p1.eq;
  assign bus.out_err   = head_p1.err;
  assign bus.occupancy = occ_p1;

endmodule

// File: tb/tb_sel_pipe_unit.sv
// Bench for sel_pipe_unit: queue-based reference model checked every cycle,
// plus directed vectors with literal expected results.
module tb_sel_pipe_unit;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sel_pipe_unit_if #(.N(N)) bus ();

  sel_pipe_unit #(.N(N), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int data;
    bit eq;
    bit err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pick by value using plain integers, sign taken from the top bit.
  function automatic exp_t model(input int m, input int a, input int b);
    exp_t e;
    int   sa;
    int   sb;
    sa = (a >= (1 << (N - 1))) ? a - (1 << N) : a;
    sb = (b >= (1 << (N - 1))) ? b - (1 << N) : b;
    e.err = 1'b0;
    case (m)
      0:       e.data = a;
      1:       e.data = b;
      2:       e.data = (a <= b) ? a : b;
      3:       e.data = (a >= b) ? a : b;
      4:       e.data = (sa <= sb) ? a : b;
      5:       e.data = (sa >= sb) ? a : b;
      default: begin e.data = a; e.err = 1'b1; end
    endcase
    e.eq = (a == b);
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit push;
    bit pop;
    if (!rst_n) begin
      q.delete();
    end else begin
      push = bus.in_valid && (q.size() < 2);
      pop  = (q.size() > 0) && bus.out_ready;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(model(int'(bus.mode), int'(bus.A), int'(bus.B)));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_occupancy", 32'(bus.occupancy), 32'd0);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      check("rst_out_data",  32'(bus.out_data),  32'd0);
      check("rst_out_eq",    32'(bus.out_eq),    32'd0);
      check("rst_out_err",   32'(bus.out_err),   32'd0);
    end else begin
      check("occ_in_range",   32'(bus.occupancy <= 2'd2), 32'd1);
      check("model_occ",      32'(bus.occupancy), 32'(q.size()));
      check("model_in_ready", 32'(bus.in_ready),  32'(q.size() < 2));
      check("model_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check("model_out_data", 32'(bus.out_data), 32'(q[0].data));
        check("model_out_eq",   32'(bus.out_eq),   32'(q[0].eq));
        check("model_out_err",  32'(bus.out_err),  32'(q[0].err));
      end
    end
  end

  // Entered at a negedge with an empty buffer and out_ready=1; leaves at a negedge.
  task automatic push_check(input string name, input logic [2:0] m, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] exp_d,
                            input logic exp_eq, input logic exp_err);
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_data"},  32'(bus.out_data),  32'(exp_d));
    check({name, "_eq"},    32'(bus.out_eq),    32'(exp_eq));
    check({name, "_err"},   32'(bus.out_err),   32'(exp_err));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.mode      = 3'b000;
    bus.A         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Idle after reset
    @(negedge clk);
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    check("idle_out_data",  32'(bus.out_data),  32'd0);
    check("idle_occupancy", 32'(bus.occupancy), 32'd0);
    check("idle_in_ready",  32'(bus.in_ready),  32'd1);

    // Mode sweep, one-cycle latency
    push_check("m000", 3'b000, 8'hF0, 8'h10, 8'hF0, 1'b0, 1'b0);
    push_check("m001", 3'b001, 8'hF0, 8'h10, 8'h10, 1'b0, 1'b0);
    push_check("m010", 3'b010, 8'hF0, 8'h10, 8'h10, 1'b0, 1'b0);
    push_check("m011", 3'b011, 8'hF0, 8'h10, 8'hF0, 1'b0, 1'b0);
    push_check("m100", 3'b100, 8'hF0, 8'h10, 8'hF0, 1'b0, 1'b0);
    push_check("m101", 3'b101, 8'hF0, 8'h10, 8'h10, 1'b0, 1'b0);
    push_check("m110", 3'b110, 8'hF0, 8'h10, 8'hF0, 1'b0, 1'b1);
    push_check("m111", 3'b111, 8'hF0, 8'h10, 8'hF0, 1'b0, 1'b1);

    // Equality and signed boundary
    push_check("eq_min", 3'b010, 8'h7F, 8'h7F, 8'h7F, 1'b1, 1'b0);
    push_check("smax_b", 3'b101, 8'h7F, 8'h80, 8'h7F, 1'b0, 1'b0);
    push_check("umax_b", 3'b011, 8'h7F, 8'h80, 8'h80, 1'b0, 1'b0);
    @(negedge clk);

    // Backpressure: two accepted, third held until room
    bus.out_ready = 1'b0;
    bus.mode      = 3'b000;
    bus.B         = 8'h00;
    bus.in_valid  = 1'b1;
    bus.A         = 8'h01;
    @(posedge clk); @(negedge clk);
    bus.A = 8'h02;
    @(posedge clk); @(negedge clk);
    bus.A = 8'h03;
    @(posedge clk); @(negedge clk);
    check("bp_occ_full",  32'(bus.occupancy), 32'd2);
    check("bp_in_ready",  32'(bus.in_ready),  32'd0);
    check("bp_head_hold", 32'(bus.out_data),  32'h01);
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp_second", 32'(bus.out_data),  32'h02);
    check("bp_occ_1",  32'(bus.occupancy), 32'd1);
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_third", 32'(bus.out_data), 32'h03);
    @(posedge clk); @(negedge clk);
    check("bp_drained", 32'(bus.out_valid), 32'd0);

    // Streaming at occupancy 1
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.mode     = 3'(i % 8);
      bus.A        = 8'(i * 37 + 5);
      bus.B        = 8'(200 - i * 23);
      @(posedge clk); @(negedge clk);
      check("stream_occ",      32'(bus.occupancy), 32'd1);
      check("stream_in_ready", 32'(bus.in_ready),  32'd1);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); @(negedge clk);

    // Asynchronous reset with a full buffer
    bus.out_ready = 1'b0;
    bus.mode      = 3'b000;
    bus.in_valid  = 1'b1;
    bus.A         = 8'h11;
    @(posedge clk); @(negedge clk);
    bus.A = 8'h22;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    check("pre_rst_occ", 32'(bus.occupancy), 32'd2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_occ",   32'(bus.occupancy), 32'd0);
    check("async_rst_ready", 32'(bus.in_ready),  32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    push_check("post_rst", 3'b000, 8'hAA, 8'h00, 8'hAA, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    check("final_empty", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sel_pipe_unit.md
Name: sel_pipe_unit

Overview:
Parametrised, pipelined successor to the ALU pass-through select stage. It picks A, B, or the min/max of A and B (signed or unsigned) under a mode code. Results are registered behind a valid/ready handshake with a 2-entry skid buffer, so the ALU result path can be stalled without losing operands. It sits between the operand fetch stage and the ALU result mux.

Parameters:
N, 8, operand/result width in bits (N >= 2)
DEPTH, 2, output buffer entries (fixed at 2; other values illegal, flagged by an elaboration check)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand set present
in_ready  out  1  unit can accept an operand set this cycle
mode  in  3  operation select, sampled with A/B
A  in  N  operand A
B  in  N  operand B
out_valid  out  1  result present at head of buffer
out_ready  in  1  consumer accepts head this cycle
out_data  out  N  selected result
out_eq  out  1  A == B for that result
out_err  out  1  mode was reserved (110/111)
occupancy  out  2  entries held, 0..2

Behaviour:
- Reset is the one clock and the one reset: asynchronous and active-low, on clk/rst_n. While rst_n=0: out_valid=0, out_data=0, out_eq=0, out_err=0, occupancy=0, in_ready=1. Buffer contents are discarded.
- Mode decode:
  - 000: A
  - 001: B
  - 010: unsigned min
  - 011: unsigned max
  - 100: signed min (two's complement)
  - 101: signed max
  - 110/111: reserved; result = A, out_err=1
- On equal operands, min and max both return A.
- Result is exactly N bits with no extension. out_eq is a bitwise compare, independent of mode.
- Accept: in_valid && in_ready on a rising edge. Result is computed combinationally from the sampled A/B/mode and written to the buffer tail.
- Deliver: out_valid && out_ready on a rising edge pops the head.
- in_ready = (occupancy < 2), driven from registered state only. There is no combinational path from out_ready to in_ready.
- Latency: a result accepted at edge k is visible at head (out_valid=1) after edge k, i.e. 1 cycle, when occupancy was 0.
- Throughput: 1 result/cycle sustained while out_ready=1.
- Simultaneous push and pop, all occupancy states:
  - Occupancy 1: the head is replaced by the next entry or the new result; occupancy stays 1.
  - Occupancy 2: push is impossible (in_ready=0); pop only, occupancy becomes 1.
  - Occupancy 0: pop is impossible (out_valid=0); push only, occupancy becomes 1.
- Ordering is strictly FIFO. out_data/out_eq/out_err are stable while out_valid=1 and out_ready=0.
- When out_valid=0, out_data/out_eq/out_err hold their last values (0 after reset); they are don't-care for consumers.
- in_valid while in_ready=0: ignored, no state change; the producer must hold its data.
- Reset asserted mid-transfer: buffer is flushed immediately and in-flight entries are lost. After deassertion the first accept behaves as from occupancy 0.
- out_valid = (occupancy != 0). occupancy is a registered counter saturating at 2 by construction; overflow and underflow are unreachable, and the bench asserts this.

Test Plan:
- Reset/idle: rst_n=0 for 3 cycles, then release -> out_valid=0, out_data=0, occupancy=0, in_ready=1.
- Mode sweep (N=8, out_ready=1), A=8'hF0, B=8'h10:
  - 000 -> F0
  - 001 -> 10
  - 010 -> 10
  - 011 -> F0
  - 100 -> F0 (-16 < 16)
  - 101 -> 10
  - 110 -> F0 with out_err=1
  - Each result appears 1 cycle after accept.
- Equality: A=B=8'h7F, mode 010 -> out_data=7F, out_eq=1. A=7F, B=80, mode 101 -> 7F, out_eq=0.
- Backpressure: out_ready=0, push 3 sets (01/02/03, mode 000) -> first two accepted, occupancy=2, in_ready=0, third held. Raise out_ready -> outputs 01, 02, 03 in order with no drops or duplicates.
- Simultaneous push/pop at occupancy 1: stream 16 results with out_ready=1 -> one result per cycle, occupancy stays 1, in_ready stays 1.
- Reset mid-stream: occupancy=2, assert rst_n=0 asynchronously between edges -> out_valid falls immediately and occupancy=0. After release, push 8'hAA mode 000 -> AA one cycle later.
